// File: rtl/alu_unit_if.sv
// Operand, control and flag bundle between the CPU datapath and the ALU.
// The tri-state result bus is kept outside so several units can share it.
interface alu_unit_if #(
   parameter int WIDTH = 32
);
   logic             oe;
   logic [3:0]       operation;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             flags_we;
   logic [2:0]       status;
   logic [2:0]       flags_q;

   modport master (
      output oe, operation, a, b, carry_in, flags_we,
      input  status, flags_q
   );

   modport slave (
      input  oe, operation, a, b, carry_in, flags_we,
      output status, flags_q
   );
endinterface

// File: rtl/alu_unit.sv
// 32-bit integer ALU: combinational result/flags, tri-state result bus,
// and a clocked flags register for conditional execution and ADC/SBC chaining.
module alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_unit_if.slave        bus,
   output wire [WIDTH-1:0]  out
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_ADC  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_SBC  = 4'h3;
   localparam logic [3:0] OP_NEG  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_NOT  = 4'h8;
   localparam logic [3:0] OP_SHL  = 4'h9;
   localparam logic [3:0] OP_SHR  = 4'hA;
   localparam logic [3:0] OP_ASHR = 4'hB;
   localparam logic [3:0] OP_ROL  = 4'hC;
   localparam logic [3:0] OP_ROR  = 4'hD;
   localparam logic [3:0] OP_PASA = 4'hE;
   localparam logic [3:0] OP_PASB = 4'hF;

   logic [WIDTH-1:0] result;
   logic             carry;
   logic [4:0]       amt;
   logic [2:0]       status;
   logic [2:0]       flags_d;
   logic [2:0]       flags_q;

   // Result and carry selection; a zero shift amount passes a and carry_in through.
   always_comb begin
      result = bus.a;
      carry  = bus.carry_in;
      amt    = bus.b[4:0];
      case (bus.operation)
         OP_ADD:  {carry, result} = {1'b0, bus.a} + {1'b0, bus.b};
         OP_ADC:  {carry, result} = {1'b0, bus.a} + {1'b0, bus.b}
                                  + {{WIDTH{1'b0}}, bus.carry_in};
         OP_SUB:  {carry, result} = {1'b0, bus.a} + {1'b0, ~bus.b}
                                  + {{WIDTH{1'b0}}, 1'b1};
         OP_SBC:  {carry, result} = {1'b0, bus.a} + {1'b0, ~bus.b}
                                  + {{WIDTH{1'b0}}, bus.carry_in};
         OP_NEG:  {carry, result} = {1'b0, ~bus.a} + {{WIDTH{1'b0}}, 1'b1};
         OP_AND:  result = bus.a & bus.b;
         OP_OR:   result = bus.a | bus.b;
         OP_XOR:  result = bus.a ^ bus.b;
         OP_NOT:  result = ~bus.a;
         OP_SHL: begin
            if (amt == 5'd0) begin
               result = bus.a;
            end else begin
               {carry, result} = {1'b0, bus.a} << amt;
            end
         end
         OP_SHR: begin
            if (amt == 5'd0) begin
               result = bus.a;
            end else begin
               {result, carry} = {bus.a, 1'b0} >> amt;
            end
         end
         OP_ASHR: begin
            if (amt == 5'd0) begin
               result = bus.a;
            end else begin
               {result, carry} = $signed({bus.a, 1'b0}) >>> amt;
            end
         end
         OP_ROL: begin
            if (amt == 5'd0) begin
               result = bus.a;
            end else begin
               result = (bus.a << amt) | (bus.a >> (WIDTH - int'(amt)));
               carry  = result[0];
            end
         end
         OP_ROR: begin
            if (amt == 5'd0) begin
               result = bus.a;
            end else begin
               result = (bus.a >> amt) | (bus.a << (WIDTH - int'(amt)));
               carry  = result[WIDTH-1];
            end
         end
         OP_PASA: result = bus.a;
         OP_PASB: result = bus.b;
         default: begin
            result = bus.a;
            carry  = bus.carry_in;
         end
      endcase
      status = {result[WIDTH-1], (result == {WIDTH{1'b0}}), carry};
   end

   // Flags register next state: load status on request, otherwise hold.
   always_comb begin
      if (bus.flags_we) begin
         flags_d = status;
      end else begin
         flags_d = flags_q;
      end
   end

   // Flags register, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign bus.status  = status;
   assign bus.flags_q = flags_q;
   assign out         = bus.oe ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_unit.sv
// Directed and randomized checks of alu_unit against an arithmetic reference model.
module tb_alu_unit;
   localparam int W = 32;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] eo;
      logic [2:0]  es;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   wire  [W-1:0]  out_w;
   logic          drv_en;
   logic [W-1:0]  drv_val;
   int            checks = 0;
   int            errors = 0;
   logic [2:0]    exp_flags;
   logic [34:0]   exp;
   vec_t          dir [17];

   alu_unit_if #(.WIDTH(W)) bus ();

   alu_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .out   (out_w)
   );

   // Another agent on the shared bus, used to see that the ALU lets go of it.
   assign out_w = drv_en ? drv_val : {W{1'bz}};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic oe, input logic we);
      bus.operation = op;
      bus.a         = a;
      bus.b         = b;
      bus.carry_in  = cin;
      bus.oe        = oe;
      bus.flags_we  = we;
   endtask

   // Returns {negative, zero, carry, result}, computed with wide integer arithmetic.
   function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned full;
      longint          diff;
      int              n;
      logic [31:0]     r;
      logic            c;
      ua   = 64'(a);
      ub   = 64'(b);
      n    = int'(b[4:0]);
      r    = a;
      c    = cin;
      full = 64'd0;
      diff = 64'sd0;
      case (op)
         4'h0: begin full = ua + ub; r = full[31:0]; c = full[32]; end
         4'h1: begin full = ua + ub + 64'(cin); r = full[31:0]; c = full[32]; end
         4'h2: begin r = a - b; c = (a >= b); end
         4'h3: begin
            diff = longint'(ua) - longint'(ub) - (cin ? 64'sd0 : 64'sd1);
            r = diff[31:0];
            c = (diff >= 64'sd0);
         end
         4'h4: begin r = 32'd0 - a; c = (a == 32'd0); end
         4'h5: r = a & b;
         4'h6: r = a | b;
         4'h7: r = a ^ b;
         4'h8: r = ~a;
         4'h9: if (n != 0) begin full = ua << n; r = full[31:0]; c = full[32]; end
         4'hA: if (n != 0) begin r = a >> n; c = ((ua >> (n - 1)) & 64'd1) != 64'd0; end
         4'hB: if (n != 0) begin
            r = $signed(a) >>> n;
            c = ((ua >> (n - 1)) & 64'd1) != 64'd0;
         end
         4'hC: if (n != 0) begin full = ((ua << 32) | ua) << n; r = full[63:32]; c = r[0]; end
         4'hD: if (n != 0) begin full = ((ua << 32) | ua) >> n; r = full[31:0]; c = r[31]; end
         4'hE: r = a;
         default: r = b;
      endcase
      return {r[31], (r == 32'd0), c, r};
   endfunction

   initial begin
      dir[0]  = '{4'h0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 3'b000};
      dir[1]  = '{4'h0, 32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0003, 3'b000};
      dir[2]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 3'b001};
      dir[3]  = '{4'h2, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 3'b011};
      dir[4]  = '{4'h2, 32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0001, 3'b001};
      dir[5]  = '{4'h2, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 3'b100};
      dir[6]  = '{4'h1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 3'b011};
      dir[7]  = '{4'h3, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 3'b001};
      dir[8]  = '{4'h9, 32'h8000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 3'b001};
      dir[9]  = '{4'hB, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'hF800_0000, 3'b100};
      dir[10] = '{4'hD, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h8000_0000, 3'b101};
      dir[11] = '{4'h9, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678, 3'b001};
      dir[12] = '{4'h9, 32'h1234_5678, 32'h0000_0020, 1'b0, 32'h1234_5678, 3'b000};
      dir[13] = '{4'hC, 32'h8000_0000, 32'h0000_0021, 1'b0, 32'h0000_0001, 3'b001};
      dir[14] = '{4'h4, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 3'b100};
      dir[15] = '{4'hA, 32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0001, 3'b001};
      dir[16] = '{4'h7, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 3'b011};

      rst_n   = 1'b0;
      drv_en  = 1'b0;
      drv_val = 32'd0;
      drive(4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
      #2;
      check_eq("reset_flags", 64'(bus.flags_q), 64'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      bus.flags_we = 1'b0;

      foreach (dir[i]) begin
         @(negedge clk);
         drive(dir[i].op, dir[i].a, dir[i].b, dir[i].cin, 1'b1, 1'b0);
         #1;
         check_eq($sformatf("dir%0d_out", i), 64'(out_w), 64'(dir[i].eo));
         check_eq($sformatf("dir%0d_status", i), 64'(bus.status), 64'(dir[i].es));
      end

      @(negedge clk);
      drive(4'h2, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
      drv_val = 32'hA5A5_0F0F;
      drv_en  = 1'b1;
      #1;
      check_eq("oe0_bus_released", 64'(out_w), 64'(32'hA5A5_0F0F));
      check_eq("oe0_status", 64'(bus.status), 64'(3'b100));
      drv_en = 1'b0;

      @(negedge clk);
      drive(4'h2, 32'd2, 32'd3, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check_eq("flags_load", 64'(bus.flags_q), 64'(3'b100));
      @(negedge clk);
      drive(4'h0, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("flags_hold", 64'(bus.flags_q), 64'(3'b100));
      check_eq("hold_status", 64'(bus.status), 64'(3'b000));

      @(negedge clk);
      drive(4'h2, 32'd2, 32'd3, 1'b0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_clear", 64'(bus.flags_q), 64'(3'b000));
      @(posedge clk);
      #1;
      check_eq("flags_in_reset", 64'(bus.flags_q), 64'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("release_no_edge", 64'(bus.flags_q), 64'(3'b000));
      @(posedge clk);
      #1;
      check_eq("release_load", 64'(bus.flags_q), 64'(3'b100));
      exp_flags = 3'b100;

      for (int k = 0; k < 400; k++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         logic        cin;
         logic        oe;
         logic        we;
         @(negedge clk);
         op  = 4'($urandom_range(15, 0));
         a   = $urandom;
         b   = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(40, 0)) : $urandom;
         cin = 1'($urandom_range(1, 0));
         oe  = ($urandom_range(3, 0) != 0);
         we  = 1'($urandom_range(1, 0));
         drive(op, a, b, cin, oe, we);
         drv_val = $urandom;
         drv_en  = !oe;
         exp = ref_alu(op, a, b, cin);
         #1;
         if (oe) begin
            check_eq($sformatf("rnd%0d_op%h_out", k, op), 64'(out_w), 64'(exp[31:0]));
         end else begin
            check_eq($sformatf("rnd%0d_op%h_bus", k, op), 64'(out_w), 64'(drv_val));
         end
         check_eq($sformatf("rnd%0d_op%h_status", k, op), 64'(bus.status), 64'(exp[34:32]));
         @(posedge clk);
         if (we) begin
            exp_flags = exp[34:32];
         end
         #1;
         check_eq($sformatf("rnd%0d_flags", k), 64'(bus.flags_q), 64'(exp_flags));
         drv_en = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
